axi4_lite_master_p: RTL and testbench

Parametrised AXI4-Lite single-outstanding master. It is the next generation of the team's fixed 32-bit user-to-AXI4-Lite bridge.
- Generalised in address width, data width, byte strobes and protection bits.
- Issues AW and W concurrently.
- Returns the slave response code and a response timeout to the user.
- Sits between a local controller (CSR sequencer, DMA descriptor fetcher) and an AXI4-Lite interconnect port.

---
 rtl/axi4_lite_pkg.sv | 32 +++
 rtl/axi_lite_timeout_cnt.sv | 32 +++
 rtl/axi4_lite_master_p.sv | 228 ++++++++++++++++++++++
 tb/tb_axi4_lite_master_p.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite master and its future slave sibling.
// Holds the FSM state encoding, response codes and parameter range checks.
package axi4_lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    typedef logic [1:0] resp_t;

    localparam resp_t OKAY   = 2'b00;
    localparam resp_t EXOKAY = 2'b01;
    localparam resp_t SLVERR = 2'b10;
    localparam resp_t DECERR = 2'b11;

    localparam int ADDR_W_MIN = 12;
    localparam int ADDR_W_MAX = 64;

    function automatic bit data_w_ok(input int w);
        return (w == 32) || (w == 64);
    endfunction

    function automatic bit addr_w_ok(input int w);
        return (w >= ADDR_W_MIN) && (w <= ADDR_W_MAX);
    endfunction

endpackage

// File: rtl/axi_lite_timeout_cnt.sv
// Saturating transaction-age counter; expired is asserted during the last
// permitted cycle so the owner can abort on the following edge.
module axi_lite_timeout_cnt #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // TIMEOUT == 0 disables expiry entirely.
    assign o_expired = (TIMEOUT > 0) && i_enable && (r_count == CNT_LAST);

endmodule

// File: rtl/axi4_lite_master_p.sv
// Single-outstanding AXI4-Lite master: one user request at a time, AW and W
// issued together, slave response or timeout reported back with a Done pulse.
module axi4_lite_master_p
    import axi4_lite_pkg::*;
#(
    parameter int         ADDR_W  = 32,
    parameter int         DATA_W  = 32,
    parameter logic [2:0] PROT    = 3'b000,
    parameter int         TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  AXI_Start,
    output logic                  AXI_Ready,
    input  logic                  AXI_WriteEn,
    input  logic [ADDR_W-1:0]     AXI_Addr,
    input  logic [DATA_W-1:0]     AXI_WData,
    input  logic [DATA_W/8-1:0]   AXI_WStrb,
    output logic [DATA_W-1:0]     AXI_RData,
    output logic [1:0]            AXI_Resp,
    output logic                  AXI_Timeout,
    output logic                  AXI_Done,

    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    localparam int STRB_W = DATA_W / 8;

    generate
        if (!data_w_ok(DATA_W)) begin : g_bad_data_w
            $error("axi4_lite_master_p: DATA_W must be 32 or 64");
        end
        if (!addr_w_ok(ADDR_W)) begin : g_bad_addr_w
            $error("axi4_lite_master_p: ADDR_W must be in 12..64");
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_resp;
    logic                r_timeout;
    logic                r_aw_done;
    logic                r_w_done;

    logic                w_accept;
    logic                w_aw_fin;
    logic                w_w_fin;
    logic                w_expired;
    logic                w_cnt_en;
    logic                w_abort;
    logic                w_awvalid;
    logic                w_wvalid;
    logic                w_bready;
    logic                w_arvalid;
    logic                w_rready;
    logic                w_ready;
    logic                w_done;

    assign w_accept = (r_state == IDLE) && AXI_Start;
    assign w_cnt_en = (r_state != IDLE) && (r_state != DONE);

    // While in WR_REQ a channel's VALID is exactly !done, so READY alone completes it.
    assign w_aw_fin = r_aw_done || M_AXI_AWREADY;
    assign w_w_fin  = r_w_done  || M_AXI_WREADY;

    axi_lite_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_accept),
        .i_enable  (w_cnt_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A handshake in the expiry cycle takes priority over the abort.
    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        w_awvalid    = 1'b0;
        w_wvalid     = 1'b0;
        w_bready     = 1'b0;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (AXI_Start) begin
                    w_state_next = AXI_WriteEn ? WR_REQ : RD_ADDR;
                end
            end
            WR_REQ: begin
                w_awvalid = !r_aw_done;
                w_wvalid  = !r_w_done;
                if (w_aw_fin && w_w_fin) begin
                    w_state_next = WR_RESP;
                end else if (w_expired) begin
                    w_state_next = DONE;
                    w_abort      = 1'b1;
                end
            end
            WR_RESP: begin
                w_bready = 1'b1;
                if (M_AXI_BVALID) begin
                    w_state_next = DONE;
                end else if (w_expired) begin
                    w_state_next = DONE;
                    w_abort      = 1'b1;
                end
            end
            RD_ADDR: begin
                w_arvalid = 1'b1;
                if (M_AXI_ARREADY) begin
                    w_state_next = RD_DATA;
                end else if (w_expired) begin
                    w_state_next = DONE;
                    w_abort      = 1'b1;
                end
            end
            RD_DATA: begin
                w_rready = 1'b1;
                if (M_AXI_RVALID) begin
                    w_state_next = DONE;
                end else if (w_expired) begin
                    w_state_next = DONE;
                    w_abort      = 1'b1;
                end
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_resp    <= OKAY;
            r_timeout <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= AXI_Addr;
                r_wdata   <= AXI_WData;
                r_wstrb   <= AXI_WStrb;
                r_timeout <= 1'b0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (r_state == WR_REQ) begin
                r_aw_done <= w_aw_fin;
                r_w_done  <= w_w_fin;
            end
            if ((r_state == WR_RESP) && M_AXI_BVALID) begin
                r_resp <= M_AXI_BRESP;
            end
            if ((r_state == RD_DATA) && M_AXI_RVALID) begin
                r_rdata <= M_AXI_RDATA;
                r_resp  <= M_AXI_RRESP;
            end
            if (w_abort) begin
                r_resp    <= SLVERR;
                r_timeout <= 1'b1;
            end
        end
    end

    assign AXI_Ready     = w_ready;
    assign AXI_Done      = w_done;
    assign AXI_Timeout   = w_done && r_timeout;
    assign AXI_Resp      = r_resp;
    assign AXI_RData     = r_rdata;

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = PROT;
    assign M_AXI_AWVALID = w_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = w_wvalid;
    assign M_AXI_BREADY  = w_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = PROT;
    assign M_AXI_ARVALID = w_arvalid;
    assign M_AXI_RREADY  = w_rready;

endmodule

// File: tb/tb_axi4_lite_master_p.sv
// Scoreboard bench for axi4_lite_master_p (64-bit data, TIMEOUT=16): directed
// transactions push expected completions, a Done monitor pops and compares.
module tb_axi4_lite_master_p;
    import axi4_lite_pkg::*;

    localparam int         AW = 32;
    localparam int         DW = 64;
    localparam int         SW = DW / 8;
    localparam int         TO = 16;
    localparam logic [2:0] PR = 3'b010;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          AXI_Start, AXI_Ready, AXI_WriteEn;
    logic [AW-1:0] AXI_Addr;
    logic [DW-1:0] AXI_WData, AXI_RData;
    logic [SW-1:0] AXI_WStrb;
    logic [1:0]    AXI_Resp;
    logic          AXI_Timeout, AXI_Done;
    logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
    logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [SW-1:0] M_AXI_WSTRB;
    logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
    logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic          M_AXI_RVALID, M_AXI_RREADY;

    always #5 clk = ~clk;

    axi4_lite_master_p #(.ADDR_W(AW), .DATA_W(DW), .PROT(PR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .AXI_Start(AXI_Start), .AXI_Ready(AXI_Ready), .AXI_WriteEn(AXI_WriteEn),
        .AXI_Addr(AXI_Addr), .AXI_WData(AXI_WData), .AXI_WStrb(AXI_WStrb),
        .AXI_RData(AXI_RData), .AXI_Resp(AXI_Resp), .AXI_Timeout(AXI_Timeout), .AXI_Done(AXI_Done),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
        .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    typedef struct {
        logic [1:0]    resp;
        logic          to;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_err    = 0;

    // Slave behaviour for the current transaction (delays counted in cycles).
    int            aw_delay, w_delay, b_delay, ar_delay, r_delay;
    bit            b_never;
    logic [1:0]    b_resp_cfg, r_resp_cfg;
    logic [DW-1:0] r_data_cfg;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [SW-1:0] exp_wstrb;
    logic [DW-1:0] model_rdata;
    int            aw_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Write slave: AW and W channels with independent delays, then B.
    initial begin : write_slave
        bit aw_ok, w_ok, aw_hit, w_hit;
        int cnt;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
        forever begin
            @(negedge clk);
            if (rst_n && (M_AXI_AWVALID || M_AXI_WVALID)) begin
                aw_ok = 1'b0; w_ok = 1'b0; cnt = 0;
                while (!(aw_ok && w_ok) && cnt < 64 && rst_n) begin
                    check("awvalid_level", M_AXI_AWVALID, !aw_ok);
                    check("wvalid_level", M_AXI_WVALID, !w_ok);
                    M_AXI_AWREADY = !aw_ok && (cnt >= aw_delay);
                    M_AXI_WREADY  = !w_ok && (cnt >= w_delay);
                    #1;
                    aw_hit = M_AXI_AWREADY && M_AXI_AWVALID;
                    w_hit  = M_AXI_WREADY && M_AXI_WVALID;
                    if (aw_hit) begin
                        aw_count++;
                        check("awaddr", M_AXI_AWADDR, exp_addr);
                        check("awprot", M_AXI_AWPROT, PR);
                    end
                    if (w_hit) begin
                        check("wdata", M_AXI_WDATA, exp_wdata);
                        check("wstrb", M_AXI_WSTRB, exp_wstrb);
                    end
                    @(negedge clk);
                    aw_ok = aw_ok || aw_hit;
                    w_ok  = w_ok || w_hit;
                    cnt++;
                end
                M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
                if (!b_never && rst_n) begin
                    repeat (b_delay) @(negedge clk);
                    M_AXI_BVALID = 1'b1; M_AXI_BRESP = b_resp_cfg;
                    #1; cnt = 0;
                    while (!M_AXI_BREADY && cnt < 64) begin @(negedge clk); #1; cnt++; end
                    @(negedge clk);
                    M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
                end
            end
        end
    end

    // Read slave: AR after ar_delay, R after a further r_delay.
    initial begin : read_slave
        int cnt;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
        forever begin
            @(negedge clk);
            if (rst_n && M_AXI_ARVALID) begin
                for (int k = 0; k < ar_delay && rst_n; k++) begin
                    check("arvalid_hold", M_AXI_ARVALID, 1);
                    @(negedge clk);
                end
                if (rst_n) begin
                    M_AXI_ARREADY = 1'b1;
                    #1;
                    check("arvalid", M_AXI_ARVALID, 1);
                    check("araddr", M_AXI_ARADDR, exp_addr);
                    check("arprot", M_AXI_ARPROT, PR);
                    @(negedge clk);
                    M_AXI_ARREADY = 1'b0;
                    for (int k = 0; k < r_delay && rst_n; k++) @(negedge clk);
                    if (rst_n) begin
                        M_AXI_RVALID = 1'b1; M_AXI_RDATA = r_data_cfg; M_AXI_RRESP = r_resp_cfg;
                        #1; cnt = 0;
                        while (!M_AXI_RREADY && cnt < 64) begin @(negedge clk); #1; cnt++; end
                        @(negedge clk);
                        M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
                    end
                end
            end
        end
    end

    // Done monitor: pops the scoreboard on every completion pulse.
    bit prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (prev_done) begin
            check("done_one_cycle", AXI_Done, 0);
            check("ready_after_done", AXI_Ready, 1);
        end
        if (AXI_Done) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL unexpected_done: actual Done=1, required no completion pending");
            end else begin
                e = exp_q.pop_front();
                check("resp", AXI_Resp, e.resp);
                check("timeout_flag", AXI_Timeout, e.to);
                check("rdata", AXI_RData, e.rdata);
                check("bus_idle_at_done",
                      {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
            end
        end
        prev_done = AXI_Done;
    end

    task automatic run(input bit wen, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [SW-1:0] wstrb, input logic [1:0] exp_resp, input bit exp_to,
                       input int exp_lat, input bit hold_start, input string name);
        exp_t e;
        int   lat;
        int   aw0;
        @(negedge clk);
        check({name, "_ready"}, AXI_Ready, 1);
        exp_addr = addr; exp_wdata = wdata; exp_wstrb = wstrb;
        AXI_Start = 1'b1; AXI_WriteEn = wen; AXI_Addr = addr; AXI_WData = wdata; AXI_WStrb = wstrb;
        if (!wen && !exp_to) model_rdata = r_data_cfg;
        e.resp = exp_resp; e.to = exp_to; e.rdata = model_rdata;
        exp_q.push_back(e);
        aw0 = aw_count;
        @(posedge clk); #1;
        // Scramble the user inputs: only the values at accept may matter.
        AXI_Addr = ~addr; AXI_WData = ~wdata; AXI_WStrb = ~wstrb; AXI_WriteEn = ~wen;
        if (!hold_start) AXI_Start = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            check({name, "_busy_not_ready"}, AXI_Ready, 0);
        end while (!AXI_Done && lat < 100);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_aw_count"}, aw_count - aw0, wen ? 1 : 0);
        AXI_Start = 1'b0;
        $display("%s: wen=%0d addr=0x%0h resp=%0d timeout=%0d rdata=0x%0h latency=%0d",
                 name, wen, addr, AXI_Resp, AXI_Timeout, AXI_RData, lat);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int lat;
        rst_n = 1'b1;
        AXI_Start = 1'b0; AXI_WriteEn = 1'b0; AXI_Addr = '0; AXI_WData = '0; AXI_WStrb = '0;
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0; b_never = 1'b0;
        b_resp_cfg = OKAY; r_resp_cfg = OKAY; r_data_cfg = '0;
        exp_addr = '0; exp_wdata = '0; exp_wstrb = '0; model_rdata = '0; aw_count = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", AXI_Ready, 1);
        check("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        check("rst_done", {AXI_Done, AXI_Timeout}, 0);
        check("rst_resp", AXI_Resp, 0);
        check("rst_rdata", AXI_RData, 0);
        check("rst_regs", {M_AXI_AWADDR, M_AXI_WSTRB}, 0);
        check("rst_wdata", M_AXI_WDATA, 0);
        rst_n = 1'b1;

        run(1, 32'h40, 64'hDEAD_BEEF, 8'h0F, OKAY, 0, 3, 0, "wr_zero_wait");

        aw_delay = 4; w_delay = 0; b_resp_cfg = SLVERR;
        run(1, 32'h104, 64'h1111_2222_3333_4444, 8'hFF, SLVERR, 0, 7, 0, "wr_w_first");

        aw_delay = 0; w_delay = 4; b_resp_cfg = EXOKAY;
        run(1, 32'h208, 64'h5555_6666_7777_8888, 8'hF0, EXOKAY, 0, 7, 0, "wr_aw_first");
        w_delay = 0; b_resp_cfg = OKAY;

        ar_delay = 2; r_delay = 5; r_data_cfg = 64'h1234_5678; r_resp_cfg = DECERR;
        run(0, 32'h300, '0, '0, DECERR, 0, 10, 0, "rd_wait");

        ar_delay = 0; r_delay = 0; r_data_cfg = 64'hA5A5_0000_FFFF_1234; r_resp_cfg = OKAY;
        run(0, 32'h308, '0, '0, OKAY, 0, 3, 0, "rd_zero_wait");

        b_never = 1'b1;
        run(1, 32'h400, 64'h0BAD_F00D, 8'h3C, SLVERR, 1, TO + 1, 0, "wr_timeout");
        b_never = 1'b0;

        run(1, 32'h48, 64'h0000_0000_CAFE_0001, 8'h01, OKAY, 0, 3, 0, "wr_after_timeout");

        run(1, 32'hFF0, 64'h0123_4567_89AB_CDEF, 8'h0F, OKAY, 0, 3, 1, "wr64_hold_start");

        // Asynchronous reset while the read waits in RD_DATA.
        ar_delay = 0; r_delay = 10; r_data_cfg = 64'h7777_7777;
        @(negedge clk);
        exp_addr = 32'h500;
        AXI_Start = 1'b1; AXI_WriteEn = 1'b0; AXI_Addr = 32'h500;
        @(posedge clk); #1;
        AXI_Start = 1'b0;
        lat = 0;
        while (!M_AXI_RREADY && lat < 20) begin @(negedge clk); lat++; end
        check("rst_mid_reached_rd_data", M_AXI_RREADY, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        check("rst_mid_done", {AXI_Done, AXI_Timeout}, 0);
        check("rst_mid_resp_rdata", {AXI_Resp, AXI_RData}, 0);
        model_rdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_ready_after", AXI_Ready, 1);
        $display("rst_mid_rd_data: reset applied in RD_DATA, ready=%0d", AXI_Ready);

        r_delay = 0; r_data_cfg = 64'hCAFE_F00D; r_resp_cfg = OKAY;
        run(0, 32'h504, '0, '0, OKAY, 0, 3, 0, "rd_after_reset");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
